// File: rtl/float_arith_unit.sv
// Single-precision add/sub, int32-to-float convert and three-way compare.
// Operands are captured on en; the result register updates one clock later.
module float_arith_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic [1:0]  cmp,
  output logic        valid
);

  localparam int unsigned DataW = 32;
  localparam int unsigned ExpW  = 8;
  localparam int unsigned FracW = 23;
  localparam int unsigned ExtW  = FracW + 4;  // hidden bit + fraction + guard/round/sticky

  localparam logic [DataW-1:0] CanonNan = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpCvt = 2'b10,
    OpCmp = 2'b11
  } opE;

  function automatic logic [4:0] lzc27(input logic [ExtW-1:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  function automatic logic [4:0] lzc32(input logic [DataW-1:0] v);
    lzc32 = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) lzc32 = 5'(31 - i);
    end
  endfunction

  // Operand capture stage
  logic             reqValid;
  opE               reqOp;
  logic [DataW-1:0] reqA;
  logic [DataW-1:0] reqB;

  always_ff @(posedge clk) begin
    if (reset) begin
      reqValid <= 1'b0;
      reqOp    <= OpAdd;
      reqA     <= '0;
      reqB     <= '0;
    end else begin
      reqValid <= en;
      if (en) begin
        reqOp <= opE'(op);
        reqA  <= a;
        reqB  <= b;
      end
    end
  end

  // Add/subtract datapath
  logic             sA, sB, sL;
  logic [ExpW-1:0]  eA, eB, eL, eS, dExp;
  logic             zA, zB, infA, infB, nanA, nanB, aBigger;
  logic [FracW:0]   mL, mS;
  logic [ExtW-1:0]  fullL, fullS, alignS, norm;
  logic [ExtW:0]    sum;
  logic [4:0]       lz;
  logic             roundUp;
  logic [FracW+1:0] mant;
  logic [FracW-1:0] fracOut;
  int               expI;
  logic [DataW-1:0] normRes, addRes;

  always_comb begin : addPath
    sA   = reqA[31];
    sB   = reqB[31] ^ (reqOp == OpSub);
    eA   = reqA[30:23];
    eB   = reqB[30:23];
    zA   = (eA == '0);
    zB   = (eB == '0);
    infA = (eA == '1) && (reqA[22:0] == '0);
    infB = (eB == '1) && (reqB[22:0] == '0);
    nanA = (eA == '1) && (reqA[22:0] != '0);
    nanB = (eB == '1) && (reqB[22:0] != '0);

    // Larger magnitude goes first so the difference never goes negative
    aBigger = (reqA[30:0] >= reqB[30:0]);
    sL = aBigger ? sA : sB;
    eL = aBigger ? eA : eB;
    eS = aBigger ? eB : eA;
    mL = {1'b1, aBigger ? reqA[22:0] : reqB[22:0]};
    mS = {1'b1, aBigger ? reqB[22:0] : reqA[22:0]};
    dExp  = eL - eS;
    fullL = {mL, 3'b000};
    fullS = {mS, 3'b000};

    alignS = 27'd1;
    if (dExp < 8'd27) begin
      alignS    = fullS >> dExp;
      alignS[0] = alignS[0] | (|(fullS & ((27'd1 << dExp) - 27'd1)));
    end

    sum = (sA ^ sB) ? ({1'b0, fullL} - {1'b0, alignS})
                    : ({1'b0, fullL} + {1'b0, alignS});
    lz  = lzc27(sum[ExtW-1:0]);

    if (sum[ExtW]) begin
      norm = {sum[ExtW:2], sum[1] | sum[0]};
      expI = int'(eL) + 1;
    end else begin
      norm = sum[ExtW-1:0] << lz;
      expI = int'(eL) - int'(lz);
    end

    roundUp = norm[2] & (norm[3] | norm[1] | norm[0]);
    mant    = {1'b0, norm[ExtW-1:3]} + 25'(roundUp);
    fracOut = mant[FracW-1:0];
    if (mant[FracW+1]) begin
      expI    = expI + 1;
      fracOut = mant[FracW:1];
    end

    if (expI >= 255)    normRes = {sL, 8'hFF, 23'd0};
    else if (expI <= 0) normRes = {sL, 31'd0};
    else                normRes = {sL, 8'(expI), fracOut};
    if (sum == '0) normRes = '0;

    if (nanA || nanB)          addRes = CanonNan;
    else if (infA && infB)     addRes = (sA == sB) ? {sA, 8'hFF, 23'd0} : CanonNan;
    else if (infA)             addRes = {sA, 8'hFF, 23'd0};
    else if (infB)             addRes = {sB, 8'hFF, 23'd0};
    else if (zA && zB)         addRes = {sA & sB, 31'd0};
    else if (zB)               addRes = {sA, reqA[30:0]};
    else if (zA)               addRes = {sB, reqB[30:0]};
    else                       addRes = normRes;
  end

  // Signed int32 to float conversion
  logic             cvSign, cvRoundUp;
  logic [DataW-1:0] cvMag, cvNorm;
  logic [4:0]       cvLz;
  logic [FracW+1:0] cvMant;
  logic [ExpW-1:0]  cvExp;
  logic [FracW-1:0] cvFrac;
  logic [DataW-1:0] cvtRes;

  always_comb begin : cvtPath
    cvSign    = reqA[31];
    cvMag     = cvSign ? (~reqA + 32'd1) : reqA;
    cvLz      = lzc32(cvMag);
    cvNorm    = cvMag << cvLz;
    cvRoundUp = cvNorm[7] & (cvNorm[8] | (|cvNorm[6:0]));
    cvMant    = {1'b0, cvNorm[31:8]} + 25'(cvRoundUp);
    cvExp     = 8'd158 - {3'b000, cvLz};
    cvFrac    = cvMant[FracW-1:0];
    if (cvMant[FracW+1]) begin
      cvExp  = cvExp + 8'd1;
      cvFrac = cvMant[FracW:1];
    end
    cvtRes = (reqA == '0) ? '0 : {cvSign, cvExp, cvFrac};
  end

  // Three-way compare on sign-magnitude keys with denormals folded to zero
  logic             cSignA, cSignB;
  logic [30:0]      cMagA, cMagB;
  logic [1:0]       cmpCode;

  always_comb begin : cmpPath
    cSignA = zA ? 1'b0 : reqA[31];
    cSignB = zB ? 1'b0 : reqB[31];
    cMagA  = zA ? '0 : reqA[30:0];
    cMagB  = zB ? '0 : reqB[30:0];
    if (nanA || nanB)                              cmpCode = 2'b10;
    else if ((cSignA == cSignB) && (cMagA == cMagB)) cmpCode = 2'b00;
    else if (cSignA != cSignB)                     cmpCode = cSignA ? 2'b11 : 2'b01;
    else if (!cSignA)                              cmpCode = (cMagA > cMagB) ? 2'b01 : 2'b11;
    else                                           cmpCode = (cMagA > cMagB) ? 2'b11 : 2'b01;
  end

  // Output register
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      cmp    <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= reqValid;
      if (reqValid) begin
        case (reqOp)
          OpAdd, OpSub: result <= addRes;
          OpCvt:        result <= cvtRes;
          default: begin
            result <= {30'd0, cmpCode};
            cmp    <= cmpCode;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_float_arith_unit.sv
// Scoreboard bench for float_arith_unit: directed and random requests checked
// against a real-arithmetic reference model.
module tb_float_arith_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result;
  logic [1:0]  cmp;
  logic        valid;

  float_arith_unit dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .a(a), .b(b),
    .result(result), .cmp(cmp), .valid(valid)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NAN = 32'h7FC0_0000;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  cmpv;
    int          edgeN;
    string       name;
  } expT;

  expT        sb[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [1:0] lastCmp = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model
  function automatic bit isNan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction
  function automatic bit isInf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 0);
  endfunction
  function automatic bit isZero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction

  function automatic real toReal(input logic [31:0] x);
    logic [63:0] d;
    if (isZero(x)) return 0.0;
    if (isInf(x)) return x[31] ? -1.0e300 : 1.0e300;
    d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] fromReal(input real r);
    logic [63:0] d;
    logic [52:0] m;
    logic [24:0] k;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    m = {1'b1, d[51:0]};
    k = {1'b0, m[52:29]};
    if (m[28] && ((|m[27:0]) || m[29])) k = k + 25'd1;
    if (k[24]) begin
      e = e + 1;
      k = k >> 1;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0) return {d[63], 31'd0};
    return {d[63], 8'(e), k[22:0]};
  endfunction

  function automatic logic [31:0] modelAdd(input logic [31:0] x, input logic [31:0] y, input logic sub);
    logic [31:0] yy;
    real r;
    yy = {y[31] ^ sub, y[30:0]};
    if (isNan(x) || isNan(yy)) return NAN;
    if (isInf(x) && isInf(yy)) return (x[31] == yy[31]) ? x : NAN;
    if (isInf(x)) return x;
    if (isInf(yy)) return yy;
    if (isZero(x) && isZero(yy)) return {x[31] & yy[31], 31'd0};
    r = toReal(x) + toReal(yy);
    if (r == 0.0) return 32'd0;
    return fromReal(r);
  endfunction

  function automatic logic [31:0] modelCvt(input logic [31:0] x);
    int v;
    v = $signed(x);
    if (v == 0) return 32'd0;
    return fromReal(real'(v));
  endfunction

  function automatic logic [1:0] modelCmp(input logic [31:0] x, input logic [31:0] y);
    real rx, ry;
    if (isNan(x) || isNan(y)) return 2'b10;
    rx = toReal(x);
    ry = toReal(y);
    if (rx == ry) return 2'b00;
    if (rx > ry) return 2'b01;
    return 2'b11;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string nm);
    expT e;
    e.cmpv = lastCmp;
    case (o)
      2'b00: e.res = modelAdd(x, y, 1'b0);
      2'b01: e.res = modelAdd(x, y, 1'b1);
      2'b10: e.res = modelCvt(x);
      default: begin
        lastCmp = modelCmp(x, y);
        e.cmpv  = lastCmp;
        e.res   = {30'd0, lastCmp};
      end
    endcase
    e.edgeN = cyc + 1;
    e.name  = nm;
    sb.push_back(e);
    en = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d responses outstanding, want 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] randFloat(input int baseE);
    logic s;
    int e;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 19))
      0: return {s, 31'd0};
      1: return {s, 8'hFF, 23'd0};
      2: return {s, 8'hFF, 23'($urandom) | 23'd1};
      3: return {s, 8'h00, 23'($urandom) | 23'd1};
      4: return {s, 31'h7F7F_FFFF};
      5: begin
        e = int'($urandom_range(1, 254));
        return {s, 8'(e), 23'($urandom)};
      end
      default: begin
        e = baseE + int'($urandom_range(0, 60)) - 30;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        return {s, 8'(e), 23'($urandom)};
      end
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge clk) begin
    expT e;
    if (valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got valid=1 want valid=0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        check32({e.name, "_latency"}, 32'(cyc), 32'(e.edgeN + 1));
        check32({e.name, "_result"}, result, e.res);
        check32({e.name, "_cmp"}, 32'(cmp), 32'(e.cmpv));
      end
    end else if (sb.size() > 0 && cyc > sb[0].edgeN + 1) begin
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL %s_valid: got no valid pulse, want one at cycle %0d", e.name, e.edgeN + 1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] x, y;
    int          base;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check32("reset_result", result, 32'd0);
    check32("reset_cmp", 32'(cmp), 32'd0);
    check32("reset_valid", 32'(valid), 32'd0);

    issue(2'b00, 32'h3F80_0000, 32'h4000_0000, "add_1_2");
    issue(2'b01, 32'h4040_0000, 32'h3F80_0000, "sub_3_1");
    issue(2'b01, 32'h3F80_0000, 32'h3F80_0000, "sub_1_1");
    issue(2'b00, 32'h3F80_0000, 32'h3380_0000, "add_tie_even");
    issue(2'b00, 32'h3F80_0000, 32'h3380_0001, "add_above_tie");
    issue(2'b00, 32'h7F7F_FFFF, 32'h7F7F_FFFF, "add_overflow");
    issue(2'b10, 32'd5, 32'h0, "cvt_5");
    issue(2'b10, 32'hFFFF_FFFF, 32'h0, "cvt_m1");
    issue(2'b10, 32'd16777217, 32'h0, "cvt_2p24p1");
    issue(2'b10, 32'h8000_0000, 32'h0, "cvt_intmin");
    issue(2'b10, 32'h0, 32'h1234_5678, "cvt_0");
    issue(2'b11, 32'h3F80_0000, 32'h4000_0000, "cmp_1_2");
    issue(2'b11, 32'h4000_0000, 32'h3F80_0000, "cmp_2_1");
    issue(2'b11, 32'h0000_0000, 32'h8000_0000, "cmp_pz_nz");
    issue(2'b11, 32'h7FC0_0000, 32'h3F80_0000, "cmp_nan");
    issue(2'b01, 32'h7F80_0000, 32'h7F80_0000, "sub_inf_inf");
    issue(2'b00, 32'h7FC0_0000, 32'h3F80_0000, "add_nan");
    issue(2'b00, 32'h0000_0001, 32'h0000_0000, "add_denorm");
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, "add_nz_nz");
    issue(2'b01, 32'h8000_0000, 32'h0000_0000, "sub_nz_pz");
    issue(2'b00, 32'hFF80_0000, 32'h3F80_0000, "add_ninf_1");
    drain();

    issue(2'b00, 32'h4000_0000, 32'h4000_0000, "b2b_add");
    issue(2'b10, 32'hFFFF_FFF6, 32'h0, "b2b_cvt");
    issue(2'b11, 32'hC000_0000, 32'h3F80_0000, "b2b_cmp");
    issue(2'b01, 32'h4120_0000, 32'h3F00_0000, "b2b_sub");
    drain();

    // Request on a reset edge is discarded
    en = 1'b1; op = 2'b00; a = 32'h3F80_0000; b = 32'h4000_0000; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; en = 1'b0; lastCmp = 2'b00;
    check32("rst_edge_result", result, 32'd0);
    check32("rst_edge_cmp", 32'(cmp), 32'd0);
    @(posedge clk); #1;
    check32("rst_edge_valid", 32'(valid), 32'd0);
    check32("rst_edge_result_hold", result, 32'd0);

    // Request accepted, then reset on the following edge
    issue(2'b11, 32'h4000_0000, 32'h3F80_0000, "cmp_pre_reset");
    drain();
    en = 1'b1; op = 2'b11; a = 32'h3F80_0000; b = 32'h4000_0000;
    @(posedge clk); #1;
    en = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; lastCmp = 2'b00;
    check32("rst_after_req_result", result, 32'd0);
    check32("rst_after_req_cmp", 32'(cmp), 32'd0);
    check32("rst_after_req_valid", 32'(valid), 32'd0);
    @(posedge clk); #1;
    check32("rst_after_req_valid2", 32'(valid), 32'd0);

    for (int i = 0; i < 1500; i++) begin
      o    = 2'($urandom_range(0, 3));
      base = int'($urandom_range(1, 254));
      x    = randFloat(base);
      y    = randFloat(base);
      if ($urandom_range(0, 5) == 0) y = x ^ 32'h8000_0000 ^ 32'($urandom_range(0, 7));
      if (o == 2'b10) x = $urandom >> $urandom_range(0, 31);
      if (o == 2'b10 && $urandom_range(0, 1) == 1) x = ~x + 32'd1;
      issue(o, x, y, $sformatf("rand%0d_op%0d_%h_%h", i, o, x, y));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/float_arith_unit.md
# float_arith_unit

Single-precision (IEEE-754 binary32) arithmetic helper for the Phaethon processor core. It performs add, subtract, signed-integer-to-float conversion and three-way compare on two 32-bit operands, one operation per request. The result is registered and delivered one clock after the request. The CPU's execute stage drives operands from its register file and writes `result`/`cmp` back after `valid`.

## Interface
Parameters: none.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high; sampled on rising edge of `clk`.
- `en` in 1: request strobe; operands and `op` sampled on the edge where `en`=1.
- `op` in 2: 00 add (a+b), 01 subtract (a−b), 10 convert (a as signed int32 → float), 11 compare (a vs b).
- `a` in 32: operand A (float, or int32 for convert).
- `b` in 32: operand B (float; ignored for convert).
- `result` out 32: float result. For compare: {30'b0, cmp code}.
- `cmp` out 2: compare code. 00 equal, 01 a>b, 11 a<b, 10 unordered. Updated only by compare ops.
- `valid` out 1: one-cycle pulse, result/cmp updated this cycle.

## Operation
- Add/sub: subtract = add with b's sign inverted. Align the smaller-exponent significand; keep guard, round and sticky bits. Add or subtract magnitudes, then normalize with a leading-zero count. Round to nearest, ties to even.
- Exponent overflow after rounding gives ±Inf (0x7F800000/0xFF800000).
- Exponent underflow (biased exp ≤ 0) gives signed zero; no subnormals produced.
- Denormal inputs (exp=0, frac≠0) are treated as zero of the same sign, for all float ops.
- Exact-zero sum gives +0, except (−0)+(−0) and (−0)−(+0), which give −0.
- NaN inputs give canonical NaN 0x7FC00000. Inf−Inf (effective subtraction of equal infinities) also gives 0x7FC00000. Inf ± finite gives that Inf.
- Convert: two's-complement int32 → float with round-to-nearest-even.
  - 0 gives 0x00000000.
  - 0x80000000 gives 0xCF000000.
  - Magnitudes > 2^24 are rounded.
- Compare:
  - Either operand NaN gives 10.
  - +0 and −0 are equal, and denormals compare as zero.
  - Otherwise ordered by sign-magnitude value; infinities are ordered normally.
  - Min/max selection is done outside this block: cmp==01 means b is the minimum; cmp==11 means b is the maximum.

## Timing
- Latency 1: `en`=1 at edge N gives `result`, `cmp` (compare only) and `valid`=1 after edge N+1.
- The add/convert datapath is combinational between the operand capture register and the output register, or computed directly into the output register. Either way, latency is exactly 1.
- Throughput 1/cycle: `en` may be high on consecutive edges; each request produces its own `valid` pulse one cycle later.
- `valid`=0 on any edge where `en`=0.
- `result` and `cmp` hold their last values until the next request of the relevant kind. A non-compare op leaves `cmp` unchanged.
- Reset values: `result`=0x00000000, `cmp`=00, `valid`=0.
- Reset has priority over `en`: a request on a reset edge is discarded and `valid` stays 0 the following cycle.
- A request accepted at edge N, followed by reset at edge N+1, produces no `valid`; outputs take their reset values.
- No backpressure: the consumer must take the result on the `valid` cycle or read the held value before issuing another request.

## Test plan
- Add / sub:
  - 0x3F800000 + 0x40000000 gives 0x40400000.
  - 0x40400000 − 0x3F800000 gives 0x40000000.
  - 0x3F800000 − 0x3F800000 gives 0x00000000.
  - `valid` pulses exactly one cycle after `en`.
- Rounding:
  - 0x3F800000 + 0x33800000 (tie) gives 0x3F800000.
  - 0x3F800000 + 0x33800001 gives 0x3F800001.
  - 0x7F7FFFFF + 0x7F7FFFFF gives 0x7F800000.
- Convert:
  - 5 gives 0x40A00000.
  - 0xFFFFFFFF gives 0xBF800000.
  - 16777217 gives 0x4B800000.
  - 0x80000000 gives 0xCF000000.
  - 0 gives 0x00000000.
- Compare:
  - (1.0, 2.0) gives cmp=11.
  - (2.0, 1.0) gives 01.
  - (0x00000000, 0x80000000) gives 00.
  - (0x7FC00000, 1.0) gives 10.
  - `result` = {30'b0, cmp}.
- Specials:
  - Inf − Inf gives 0x7FC00000.
  - NaN + 1.0 gives 0x7FC00000.
  - Denormal 0x00000001 + 0x00000000 gives 0x00000000.
- Control:
  - Back-to-back `en` for 4 cycles with mixed ops gives 4 consecutive `valid` pulses with in-order results.
  - `en` asserted on a reset edge gives no `valid` and outputs at reset values.
